// File: rtl/fadd_pipe.sv
// Three-stage pipelined binary32 adder (RNE) with valid/ready on both sides and a pass-through caller tag.
// Define FADD_PIPE_SUB_EN to add an op_sub input that turns the operation into x1 - x2.
module fadd_pipe #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x1,
  input  logic [31:0]      x2,
  input  logic [TAG_W-1:0] in_tag,
`ifdef FADD_PIPE_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      y,
  output logic             ovf,
  output logic [TAG_W-1:0] out_tag
);

  function automatic logic [4:0] lzc26(input logic [25:0] v);
    logic [4:0] c;
    c = 5'd26;
    for (int i = 0; i < 26; i++)
      if (v[i]) c = 5'(25 - i);
    return c;
  endfunction

  logic s1_v, s2_v, s3_v, ld1, ld2, ld3;
  assign ld3       = !s3_v || out_ready;
  assign ld2       = !s2_v || ld3;
  assign ld1       = !s1_v || ld2;
  assign in_ready  = ld1;
  assign out_valid = s3_v;

  // ---------------- S1: unpack / swap / align ----------------
  logic neg_b;
`ifdef FADD_PIPE_SUB_EN
  assign neg_b = op_sub;
`else
  assign neg_b = 1'b0;
`endif

  logic        sa, sb, a_max, b_max, a_nan, b_nan, a_inf, b_inf, swap;
  logic [7:0]  ea, eb, e_big, e_sml, d, dsat;
  logic [25:0] ma, mb, m_big, m_sml;
  logic        s_big, s_sml;
  logic [51:0] shf;
  logic        sp;
  logic [31:0] spv;

  assign sa    = x1[31];
  assign sb    = x2[31] ^ neg_b;
  assign a_max = &x1[30:23];
  assign b_max = &x2[30:23];
  assign a_nan = a_max && (|x1[22:0]);
  assign b_nan = b_max && (|x2[22:0]);
  assign a_inf = a_max && !(|x1[22:0]);
  assign b_inf = b_max && !(|x2[22:0]);

  // Subnormals: hidden bit 0, effective exponent 1. Two zero LSBs are guard/round.
  assign ea = (x1[30:23] == 8'd0) ? 8'd1 : x1[30:23];
  assign eb = (x2[30:23] == 8'd0) ? 8'd1 : x2[30:23];
  assign ma = {|x1[30:23], x1[22:0], 2'b00};
  assign mb = {|x2[30:23], x2[22:0], 2'b00};

  assign swap  = (eb > ea) || ((eb == ea) && (mb > ma));
  assign e_big = swap ? eb : ea;
  assign e_sml = swap ? ea : eb;
  assign m_big = swap ? mb : ma;
  assign m_sml = swap ? ma : mb;
  assign s_big = swap ? sb : sa;
  assign s_sml = swap ? sa : sb;
  assign d     = e_big - e_sml;
  assign dsat  = (d >= 8'd26) ? 8'd26 : d;
  assign shf   = {m_sml, 26'd0} >> dsat;

  always_comb begin
    sp  = 1'b0;
    spv = 32'd0;
    if (a_nan) begin
      sp  = 1'b1;
      spv = {x1[31:23], 1'b1, x1[21:0]};
    end else if (b_nan) begin
      sp  = 1'b1;
      spv = {sb, x2[30:23], 1'b1, x2[21:0]};
    end else if (a_inf && b_inf) begin
      sp  = 1'b1;
      spv = (sa == sb) ? {sa, 8'hFF, 23'd0} : 32'hFFC0_0000;
    end else if (a_inf) begin
      sp  = 1'b1;
      spv = {sa, 8'hFF, 23'd0};
    end else if (b_inf) begin
      sp  = 1'b1;
      spv = {sb, 8'hFF, 23'd0};
    end
  end

  logic             s1_sb, s1_ss, s1_st, s1_zs, s1_sp;
  logic [7:0]       s1_e;
  logic [25:0]      s1_mb, s1_ms;
  logic [31:0]      s1_spv;
  logic [TAG_W-1:0] s1_tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s1_v <= 1'b0;
    else if (ld1) s1_v <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (ld1 && in_valid) begin
      s1_sb  <= s_big;
      s1_ss  <= s_sml;
      s1_e   <= e_big;
      s1_mb  <= m_big;
      s1_ms  <= shf[51:26];
      s1_st  <= |shf[25:0];
      s1_zs  <= sa & sb;
      s1_sp  <= sp;
      s1_spv <= spv;
      s1_tag <= in_tag;
    end
  end

  // ---------------- S2: add / leading-zero count ----------------
  // Sticky rides as an extra LSB so a subtraction borrows through it correctly.
  logic [27:0] opa, opb, sum;
  assign opa = {1'b0, s1_mb, 1'b0};
  assign opb = {1'b0, s1_ms, s1_st};
  assign sum = (s1_sb ^ s1_ss) ? (opa - opb) : (opa + opb);

  logic             s2_s, s2_zs, s2_sp;
  logic [7:0]       s2_e;
  logic [27:0]      s2_sum;
  logic [4:0]       s2_lz;
  logic [31:0]      s2_spv;
  logic [TAG_W-1:0] s2_tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s2_v <= 1'b0;
    else if (ld2) s2_v <= s1_v;
  end

  always_ff @(posedge clk) begin
    if (ld2 && s1_v) begin
      s2_s   <= s1_sb;
      s2_zs  <= s1_zs;
      s2_sp  <= s1_sp;
      s2_e   <= s1_e;
      s2_sum <= sum;
      s2_lz  <= lzc26(sum[26:1]);
      s2_spv <= s1_spv;
      s2_tag <= s1_tag;
    end
  end

  // ---------------- S3: normalize / round / special mux ----------------
  logic [26:0] s27;
  logic [7:0]  lim, sh;
  logic [25:0] n;
  logic [23:0] m24;
  logic        g, rs, ru;
  logic [8:0]  e9, ef;
  logic [24:0] r25;
  logic [22:0] fr;
  logic [31:0] y_n;
  logic        ovf_n;

  assign s27 = s2_sum[27:1];

  always_comb begin
    lim   = s2_e - 8'd1;
    sh    = 8'd0;
    n     = 26'd0;
    m24   = 24'd0;
    g     = 1'b0;
    rs    = 1'b0;
    e9    = 9'd0;
    ef    = 9'd0;
    fr    = 23'd0;
    y_n   = 32'd0;
    ovf_n = 1'b0;
    // Left shift is clamped so the exponent stops at 1; what remains is subnormal.
    sh = ({3'b0, s2_lz} < lim) ? {3'b0, s2_lz} : lim;
    n  = s27[25:0] << sh;
    if (s27[26]) begin
      m24 = s27[26:3];
      g   = s27[2];
      rs  = s27[1] | s27[0] | s2_sum[0];
      e9  = {1'b0, s2_e} + 9'd1;
    end else begin
      m24 = n[25:2];
      g   = n[1];
      rs  = n[0] | s2_sum[0];
      e9  = {1'b0, s2_e} - {1'b0, sh};
    end
    ru  = g & (rs | m24[0]);
    r25 = {1'b0, m24} + {24'd0, ru};
    if (r25[24]) begin
      ef = e9 + 9'd1;
      fr = r25[23:1];
    end else begin
      ef = r25[23] ? e9 : 9'd0;
      fr = r25[22:0];
    end
    if (s2_sp) begin
      y_n = s2_spv;
    end else if ((s27 == 27'd0) && !s2_sum[0]) begin
      y_n = {s2_zs, 31'd0};
    end else if (ef >= 9'd255) begin
      y_n   = {s2_s, 8'hFF, 23'd0};
      ovf_n = 1'b1;
    end else begin
      y_n = {s2_s, ef[7:0], fr};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_v    <= 1'b0;
      y       <= 32'd0;
      ovf     <= 1'b0;
      out_tag <= '0;
    end else if (ld3) begin
      s3_v <= s2_v;
      if (s2_v) begin
        y       <= y_n;
        ovf     <= ovf_n;
        out_tag <= s2_tag;
      end
    end
  end

endmodule

// File: tb/tb_fadd_pipe.sv
// Directed bench for fadd_pipe: vector table with latency checks, back-pressure and mid-flight reset sequences.
module tb_fadd_pipe;
  logic        clk, rst, in_valid, in_ready, out_valid, out_ready, ovf;
  logic [31:0] x1, x2, y;
  logic [3:0]  in_tag, out_tag;
`ifdef FADD_PIPE_SUB_EN
  logic        op_sub;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  fadd_pipe #(.TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .in_tag(in_tag),
`ifdef FADD_PIPE_SUB_EN
    .op_sub(op_sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .ovf(ovf), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        o;
  } vec_t;

  vec_t tv[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Issue one op at posedge+1 with out_ready high; result must appear in the 3rd cycle after the accept edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t,
                        input logic [31:0] ey, input logic eo, input string nm);
    int w, lat;
    in_valid = 1'b1; x1 = a; x2 = b; in_tag = t;
    #1;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk({nm, ".accept"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    chk({nm, ".lat"}, 32'(lat), 32'd3);
    chk({nm, ".y"}, y, ey);
    chk({nm, ".ovf"}, {31'd0, ovf}, {31'd0, eo});
    chk({nm, ".tag"}, {28'd0, out_tag}, {28'd0, t});
    @(posedge clk); #1;
  endtask

  logic [31:0] bp_b[7];
  logic [31:0] bp_y[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0}; // 1+1
    tv[1]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1}; // overflow
    tv[2]  = '{32'h4B800000, 32'h3F800000, 32'h4B800000, 1'b0}; // tie, stays even
    tv[3]  = '{32'h4B800001, 32'h3F800000, 32'h4B800002, 1'b0}; // tie, rounds to even
    tv[4]  = '{32'h3F800000, 32'h33800001, 32'h3F800001, 1'b0}; // above half via sticky
    tv[5]  = '{32'h3FFFFFFF, 32'h33800000, 32'h40000000, 1'b0}; // round carry-out
    tv[6]  = '{32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0}; // exact cancel
    tv[7]  = '{32'h00000001, 32'h00000001, 32'h00000002, 1'b0}; // subnormals
    tv[8]  = '{32'h00800000, 32'h80000001, 32'h007FFFFF, 1'b0}; // normal -> subnormal
    tv[9]  = '{32'h007FFFFF, 32'h00000001, 32'h00800000, 1'b0}; // subnormal -> normal
    tv[10] = '{32'h3F800001, 32'hBF800000, 32'h34000000, 1'b0}; // deep normalize
    tv[11] = '{32'h7F000000, 32'h00000001, 32'h7F000000, 1'b0}; // saturated align
    tv[12] = '{32'h80000000, 32'h80000000, 32'h80000000, 1'b0}; // -0 + -0
    tv[13] = '{32'h80000000, 32'h00000000, 32'h00000000, 1'b0}; // -0 + +0
    tv[14] = '{32'h7F800000, 32'hFF800000, 32'hFFC00000, 1'b0}; // inf - inf
    tv[15] = '{32'h7FA00000, 32'h3F800000, 32'h7FE00000, 1'b0}; // sNaN quieted
    tv[16] = '{32'hFF800000, 32'h42000000, 32'hFF800000, 1'b0}; // -inf + finite
    tv[17] = '{32'h7F800001, 32'hFFC00000, 32'h7FC00001, 1'b0}; // x1 NaN wins

    bp_b[0] = 32'h0; bp_b[1] = 32'h3F800000; bp_b[2] = 32'h40000000; bp_b[3] = 32'h40400000;
    bp_b[4] = 32'h40800000; bp_b[5] = 32'h40A00000; bp_b[6] = 32'h0;
    bp_y[0] = 32'h0; bp_y[1] = 32'h40000000; bp_y[2] = 32'h40400000; bp_y[3] = 32'h40800000;
    bp_y[4] = 32'h40A00000; bp_y[5] = 32'h40C00000; bp_y[6] = 32'h0;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x1 = 32'd0; x2 = 32'd0; in_tag = 4'd0;
`ifdef FADD_PIPE_SUB_EN
    op_sub = 1'b0;
`endif
    #12 rst = 1'b0;
    #1;
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.y", y, 32'd0);
    chk("rst.ovf", {31'd0, ovf}, 32'd0);
    chk("rst.out_tag", {28'd0, out_tag}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 18; i++)
      run_op(tv[i].a, tv[i].b, 4'(i), tv[i].y, tv[i].o, $sformatf("vec%0d", i));

    // Back-pressure: five ops against a stalled consumer, then release.
    begin
      int nt, et;
      logic acc, drn;
      nt = 1; et = 1;
      for (int cyc = 0; cyc < 40 && et <= 5; cyc++) begin
        out_ready = (cyc >= 6);
        in_valid  = (nt <= 5);
        x1        = 32'h3F800000;
        x2        = bp_b[nt];
        in_tag    = 4'(nt);
        #1;
        if (cyc == 5) begin
          chk("bp.full_in_ready", {31'd0, in_ready}, 32'd0);
          chk("bp.accepts", 32'(nt - 1), 32'd3);
          chk("bp.hold_valid", {31'd0, out_valid}, 32'd1);
          chk("bp.hold_y", y, 32'h40000000);
          chk("bp.hold_tag", {28'd0, out_tag}, 32'd1);
        end
        if (cyc == 6) chk("bp.full_drain_in_ready", {31'd0, in_ready}, 32'd1);
        acc = in_valid && in_ready;
        drn = out_valid && out_ready;
        if (drn) begin
          chk($sformatf("bp.tag%0d", et), {28'd0, out_tag}, 32'(et));
          chk($sformatf("bp.y%0d", et), y, bp_y[et]);
          et++;
        end
        @(posedge clk); #1;
        if (acc) nt++;
      end
      in_valid = 1'b0;
      chk("bp.all_out", 32'(et), 32'd6);
    end
    repeat (3) @(posedge clk);
    #1;

    // Reset with two ops in flight (one already at the output).
    out_ready = 1'b1;
    in_valid = 1'b1; x1 = 32'h3F800000; x2 = 32'h3F800000; in_tag = 4'd7;
    @(posedge clk); #1;
    in_tag = 4'd8;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid.pre_valid", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid.valid_now", {31'd0, out_valid}, 32'd0);
    chk("mid.in_ready", {31'd0, in_ready}, 32'd1);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
        if (out_valid) seen++;
        @(posedge clk); #1;
      end
      chk("mid.none_emerge", 32'(seen), 32'd0);
    end
    run_op(32'h40400000, 32'h3F800000, 4'd9, 32'h40800000, 1'b0, "post_rst");

`ifdef FADD_PIPE_SUB_EN
    op_sub = 1'b1;
    run_op(32'h40400000, 32'h3F800000, 4'd3, 32'h40000000, 1'b0, "sub");
    run_op(32'h3F800000, 32'h7FA00000, 4'd4, 32'hFFE00000, 1'b0, "sub_nan");
    op_sub = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
